// File: rtl/mem_ctrl.sv
// ============================================================================
//  Module      : mem_ctrl
//  Description : Shares one byte-wide RAM port between a 4-byte instruction
//                fetch FSM and a higher-priority data-stage byte port.
//                Optional branch-flush input enabled by MEM_CTRL_FLUSH_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_done_o,
    output logic [31:0] if_inst_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [7:0]  mem_data_i,
    output logic [7:0]  mem_data_o,
    output logic [31:0] ram_a_o,
    output logic        ram_wr_o,
    output logic [7:0]  ram_dout_o,
    input  logic [7:0]  ram_din_i
`ifdef MEM_CTRL_FLUSH_EN
    ,
    input  logic        flush_i
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_B0   = 3'd1,
        S_B1   = 3'd2,
        S_B2   = 3'd3,
        S_B3   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_fetch_addr;
    logic [23:0] r_asm;
    logic [31:0] r_inst;

    logic        w_flush;
    logic        w_accept;
    logic        w_abort;
    logic        w_done;
    logic        w_fetching;
    logic [31:0] w_ofs;
    logic [31:0] w_inst_done;

`ifdef MEM_CTRL_FLUSH_EN
    assign w_flush = flush_i;
`else
    assign w_flush = 1'b0;
`endif

    assign w_accept    = (r_state == S_IDLE) && if_req_i && !mem_req_i && !w_flush;
    assign w_abort     = (r_state != S_IDLE) && (mem_req_i || w_flush);
    assign w_done      = (r_state == S_DONE) && !mem_req_i && !w_flush;
    assign w_fetching  = (r_state == S_B0) || (r_state == S_B1) ||
                         (r_state == S_B2) || (r_state == S_B3);
    // The last byte arrives in the DONE cycle itself, so it bypasses the assembly register.
    assign w_inst_done = {ram_din_i, r_asm};

    always_comb begin
        w_next = r_state;
        if (w_flush) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_next = w_accept  ? S_B0   : S_IDLE;
                S_B0:    w_next = mem_req_i ? S_IDLE : S_B1;
                S_B1:    w_next = mem_req_i ? S_IDLE : S_B2;
                S_B2:    w_next = mem_req_i ? S_IDLE : S_B3;
                S_B3:    w_next = mem_req_i ? S_IDLE : S_DONE;
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_ofs = 32'd0;
        case (r_state)
            S_B1:    w_ofs = 32'd1;
            S_B2:    w_ofs = 32'd2;
            S_B3:    w_ofs = 32'd3;
            default: w_ofs = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_fetch_addr <= 32'd0;
            r_asm        <= 24'd0;
            r_inst       <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_fetch_addr <= if_addr_i;
            end
            if (w_abort) begin
                r_asm <= 24'd0;
            end else begin
                case (r_state)
                    S_B1:    r_asm[7:0]   <= ram_din_i;
                    S_B2:    r_asm[15:8]  <= ram_din_i;
                    S_B3:    r_asm[23:16] <= ram_din_i;
                    default: r_asm        <= r_asm;
                endcase
            end
            if (w_done) begin
                r_inst <= w_inst_done;
            end
        end
    end

    // Data port wins the RAM outright; reset forces the RAM bus quiet.
    always_comb begin
        ram_a_o    = 32'd0;
        ram_wr_o   = 1'b0;
        ram_dout_o = 8'd0;
        if (rst) begin
            ram_a_o    = 32'd0;
            ram_wr_o   = 1'b0;
            ram_dout_o = 8'd0;
        end else if (mem_req_i) begin
            ram_a_o    = mem_addr_i;
            ram_wr_o   = mem_we_i;
            ram_dout_o = mem_data_i;
        end else if (w_fetching) begin
            ram_a_o    = r_fetch_addr + w_ofs;
        end
    end

    assign mem_data_o = ram_din_i;
    assign if_done_o  = w_done;
    assign if_inst_o  = w_done ? w_inst_done : r_inst;

endmodule

`default_nettype wire

// File: tb/tb_mem_ctrl.sv
// ============================================================================
//  Module      : tb_mem_ctrl
//  Description : Self-checking bench for mem_ctrl with a byte RAM and a
//                word-level fetch reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_done_o;
    logic [31:0] if_inst_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [7:0]  mem_data_i;
    logic [7:0]  mem_data_o;
    logic [31:0] ram_a_o;
    logic        ram_wr_o;
    logic [7:0]  ram_dout_o;
    logic [7:0]  ram_din_i;
`ifdef MEM_CTRL_FLUSH_EN
    logic        flush_i;
`endif

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] last_inst;

    mem_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .if_req_i   (if_req_i),
        .if_addr_i  (if_addr_i),
        .if_done_o  (if_done_o),
        .if_inst_o  (if_inst_o),
        .mem_req_i  (mem_req_i),
        .mem_we_i   (mem_we_i),
        .mem_addr_i (mem_addr_i),
        .mem_data_i (mem_data_i),
        .mem_data_o (mem_data_o),
        .ram_a_o    (ram_a_o),
        .ram_wr_o   (ram_wr_o),
        .ram_dout_o (ram_dout_o),
        .ram_din_i  (ram_din_i)
`ifdef MEM_CTRL_FLUSH_EN
        ,
        .flush_i    (flush_i)
`endif
    );

    always #5 clk = ~clk;

    // 64 KiB byte RAM mirrored across the address space, one-cycle read latency.
    logic [7:0]  mem [0:65535];
    logic        tb_wr_en = 1'b0;
    logic [15:0] tb_wr_a  = 16'd0;
    logic [7:0]  tb_wr_d  = 8'd0;

    always @(posedge clk) begin
        if (tb_wr_en)      mem[tb_wr_a] <= tb_wr_d;
        else if (ram_wr_o) mem[ram_a_o[15:0]] <= ram_dout_o;
        ram_din_i <= mem[ram_a_o[15:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rd(input logic [31:0] a);
        return mem[a[15:0]];
    endfunction

    // Little-endian word at byte address a, wrapping modulo 2^32.
    function automatic logic [31:0] model_word(input logic [31:0] a);
        return {rd(a + 32'd3), rd(a + 32'd2), rd(a + 32'd1), rd(a)};
    endfunction

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        tb_wr_a  = a[15:0];
        tb_wr_d  = d;
        tb_wr_en = 1'b1;
        next_cyc();
        tb_wr_en = 1'b0;
    endtask

    task automatic poke_word(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) poke(a + i, w[8*i +: 8]);
    endtask

    // One fetch, optionally preempted for one cycle by a data access at cycle pre_at.
    task automatic do_fetch(input string tag, input logic [31:0] addr, input int pre_at,
                            input logic pre_we, input logic [31:0] pa, input logic [7:0] pd);
        int          acc;
        int          seen;
        int          ndone;
        logic [7:0]  old_pa;
        acc    = (pre_at > 0) ? pre_at + 1 : 0;
        seen   = -1;
        ndone  = 0;
        old_pa = rd(pa);
        if_req_i  = 1'b1;
        if_addr_i = addr;
        for (int c = 0; c <= acc + 7; c++) begin
            if (c == acc + 1) if_addr_i = $urandom;
            if (pre_at > 0 && c == pre_at) begin
                mem_req_i  = 1'b1;
                mem_we_i   = pre_we;
                mem_addr_i = pa;
                mem_data_i = pd;
            end
            sample();
            if (pre_at > 0 && c == pre_at) begin
                check({tag, " pre_a"}, ram_a_o, pa);
                check({tag, " pre_wr"}, {31'd0, ram_wr_o}, {31'd0, pre_we});
                check({tag, " pre_dout"}, {24'd0, ram_dout_o}, {24'd0, pd});
            end else if (c > acc && c < acc + 5) begin
                check({tag, " fetch_a"}, ram_a_o, addr + 32'(c - acc - 1));
                check({tag, " fetch_wr"}, {31'd0, ram_wr_o}, 32'd0);
            end
            if (pre_at > 0 && c == pre_at + 1 && !pre_we)
                check({tag, " rd_byte"}, {24'd0, mem_data_o}, {24'd0, old_pa});
            if (if_done_o === 1'b1) begin
                ndone++;
                if (seen < 0) begin
                    seen      = c;
                    last_inst = if_inst_o;
                end
            end
            next_cyc();
            if (pre_at > 0 && c == pre_at) begin
                mem_req_i = 1'b0;
                mem_we_i  = 1'b0;
                if (pre_we) check({tag, " ram_written"}, {24'd0, rd(pa)}, {24'd0, pd});
            end
            if (c == acc + 5) if_req_i = 1'b0;
        end
        check({tag, " latency"}, 32'(seen), 32'(acc + 5));
        check({tag, " done_count"}, 32'(ndone), 32'd1);
        check({tag, " inst"}, last_inst, model_word(addr));
        sample();
        check({tag, " inst_hold"}, if_inst_o, model_word(addr));
        next_cyc();
    endtask

    initial begin
        int ndone;
        logic [31:0] a;
        rst        = 1'b1;
        if_req_i   = 1'b0;
        if_addr_i  = 32'd0;
        mem_req_i  = 1'b0;
        mem_we_i   = 1'b0;
        mem_addr_i = 32'd0;
        mem_data_i = 8'd0;
        last_inst  = 32'd0;
`ifdef MEM_CTRL_FLUSH_EN
        flush_i    = 1'b0;
`endif
        #2;
        check("rst done", {31'd0, if_done_o}, 32'd0);
        check("rst inst", if_inst_o, 32'd0);
        mem_req_i  = 1'b1;
        mem_we_i   = 1'b1;
        mem_addr_i = 32'h1234_5678;
        mem_data_i = 8'hA5;
        #1;
        check("rst ram_a", ram_a_o, 32'd0);
        check("rst ram_wr", {31'd0, ram_wr_o}, 32'd0);
        check("rst ram_dout", {24'd0, ram_dout_o}, 32'd0);
        mem_req_i = 1'b0;
        mem_we_i  = 1'b0;
        next_cyc();
        next_cyc();
        rst = 1'b0;

        if_addr_i = 32'hDEAD_BEEF;
        sample();
        check("idle ram_a", ram_a_o, 32'd0);
        check("idle ram_dout", {24'd0, ram_dout_o}, 32'd0);
        next_cyc();

        poke_word(32'h100, 32'h00A0_0513);
        do_fetch("basic", 32'h100, 0, 1'b0, 32'd0, 8'd0);
        check("basic word", last_inst, 32'h00A0_0513);

        poke_word(32'h300, $urandom);
        do_fetch("preempt_b2", 32'h300, 3, 1'b1, 32'h2000, 8'h5A);

        poke_word(32'hFFFF_FFFE, 32'h4433_2211);
        do_fetch("wrap", 32'hFFFF_FFFE, 0, 1'b0, 32'd0, 8'd0);
        check("wrap word", last_inst, 32'h4433_2211);

        // Asynchronous reset in B1 drops the fetch.
        poke_word(32'h400, 32'hCAFE_F00D);
        if_req_i  = 1'b1;
        if_addr_i = 32'h400;
        next_cyc();
        next_cyc();
        #2;
        rst        = 1'b1;
        mem_req_i  = 1'b1;
        mem_we_i   = 1'b1;
        mem_addr_i = 32'h0000_0404;
        mem_data_i = 8'h77;
        #1;
        check("arst ram_wr", {31'd0, ram_wr_o}, 32'd0);
        check("arst ram_a", ram_a_o, 32'd0);
        check("arst inst", if_inst_o, 32'd0);
        check("arst done", {31'd0, if_done_o}, 32'd0);
        mem_req_i = 1'b0;
        mem_we_i  = 1'b0;
        if_req_i  = 1'b0;
        next_cyc();
        rst   = 1'b0;
        ndone = 0;
        for (int c = 0; c < 7; c++) begin
            sample();
            if (if_done_o === 1'b1) ndone++;
            if (c == 1) check("arst idle_a", ram_a_o, 32'd0);
            next_cyc();
        end
        check("arst no_done", 32'(ndone), 32'd0);

        for (int i = 0; i < 10; i++) begin
            a = $urandom;
            poke_word(a, $urandom);
            do_fetch("rand", a, int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                     $urandom, 8'($urandom));
        end

`ifdef MEM_CTRL_FLUSH_EN
        poke_word(32'h200, 32'h1122_3344);
        if_req_i  = 1'b1;
        if_addr_i = 32'h100;
        for (int c = 0; c < 5; c++) next_cyc();
        flush_i = 1'b1;
        sample();
        check("flush done_suppressed", {31'd0, if_done_o}, 32'd0);
        next_cyc();
        flush_i  = 1'b0;
        if_req_i = 1'b0;
        next_cyc();
        do_fetch("flush_refetch", 32'h200, 0, 1'b0, 32'd0, 8'd0);
        check("flush word", last_inst, 32'h1122_3344);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL provide: clk  input  1  single system clock, rising-edge.
REQ-002 SHALL provide: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL provide: if_req_i  input  1  instruction-fetch request, held high until if_done_o.
REQ-004 SHALL provide: if_addr_i  input  32  byte address of the instruction word.
REQ-005 SHALL provide: if_done_o  output  1  one-cycle pulse, fetched word valid.
REQ-006 SHALL provide: if_inst_o  output  32  fetched instruction, little-endian assembled.
REQ-007 SHALL provide: mem_req_i  input  1  data-stage byte access request, from the memory stage.
REQ-008 SHALL provide: mem_we_i  input  1  data-stage write enable.
REQ-009 SHALL provide: mem_addr_i  input  32  data-stage byte address.
REQ-010 SHALL provide: mem_data_i  input  8  data-stage write byte.
REQ-011 SHALL provide: mem_data_o  output  8  read byte returned to the data stage.
REQ-012 SHALL provide: ram_a_o  output  32  RAM byte address.
REQ-013 SHALL provide: ram_wr_o  output  1  RAM write strobe.
REQ-014 SHALL provide: ram_dout_o  output  8  RAM write byte.
REQ-015 SHALL provide: ram_din_i  input  8  RAM read byte; valid in cycle k+1 for the address driven in cycle k.
REQ-016 SHALL provide, only under MEM_CTRL_FLUSH_EN: flush_i  input  1  branch flush, abort fetch.

Function
REQ-017 SHALL give the data port absolute priority: when mem_req_i=1, ram_a_o=mem_addr_i, ram_wr_o=mem_we_i, and ram_dout_o=mem_data_i combinationally in the same cycle.
REQ-018 SHALL drive mem_data_o=ram_din_i combinationally at all times; the data stage owns the byte-sequencing and timing.
REQ-019 SHALL use a fetch FSM with states IDLE, B0, B1, B2, B3, DONE, encoded in 3 bits.
REQ-020 SHALL transition IDLE->B0 when if_req_i=1 and mem_req_i=0, latching if_addr_i into fetch_addr.
REQ-021 SHALL, in B0..B3 (when not preempted), drive ram_a_o=fetch_addr+n with ram_wr_o=0, where n is the state index and the add is modulo 2^32.
REQ-022 SHALL capture ram_din_i into byte n-1 of the assembly register in states B1..B3 and DONE.
REQ-023 SHALL, in DONE, assert if_done_o for exactly one cycle with if_inst_o={b3,b2,b1,b0}, then return to IDLE.
REQ-024 SHALL achieve a fetch latency of 5 cycles from acceptance to if_done_o when not preempted.
REQ-025 SHALL treat mem_req_i=1 in any of B0..DONE as a preemption: discard partial bytes, go to IDLE, emit no if_done_o, and re-accept if_req_i once mem_req_i=0.
REQ-026 SHALL ignore changes to if_addr_i after acceptance.
REQ-027 SHALL hold if_inst_o stable until the next DONE.
REQ-028 SHALL not re-accept in the DONE cycle; the earliest next acceptance is the cycle after DONE.
REQ-029 SHALL, when idle with mem_req_i=0, drive ram_a_o=0, ram_wr_o=0, and ram_dout_o=0.

Reset
REQ-030 SHALL, on rst=1 (asynchronous), immediately set FSM=IDLE, if_done_o=0, if_inst_o=0, assembly register=0, and fetch_addr=0.
REQ-031 SHALL, during reset, hold ram_wr_o=0, ram_a_o=0, and ram_dout_o=0 regardless of mem_req_i.
REQ-032 SHALL, on rst asserted mid-fetch, drop the fetch with no if_done_o.

Configuration
REQ-033 SHALL, with MEM_CTRL_FLUSH_EN defined, make flush_i=1 force the FSM to IDLE on the next edge from any state, suppressing if_done_o even in DONE.
REQ-034 SHALL give flush priority below rst and above acceptance, so that a flush in IDLE blocks acceptance that cycle.
REQ-035 SHALL, without MEM_CTRL_FLUSH_EN, omit the flush_i port and always complete fetches unless preempted or reset.

Verification
REQ-036 SHALL verify: RAM[0x100..0x103]=13,05,A0,00 and if_req_i=1 with addr=0x100 -> if_done_o at cycle 5 with if_inst_o=0x00A00513.
REQ-037 SHALL verify: mem_req_i=1, we=1, addr=0x2000, data=0x5A during fetch state B2 -> RAM[0x2000]=0x5A that cycle; fetch restarts and if_done_o occurs 5 cycles after mem_req_i falls.
REQ-038 SHALL verify: if_addr_i=0xFFFFFFFE -> ram_a_o sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
REQ-039 SHALL verify: rst pulsed asynchronously in B1 -> ram_wr_o=0 and FSM=IDLE immediately, with no if_done_o.
REQ-040 SHALL verify, with MEM_CTRL_FLUSH_EN: flush_i=1 in DONE -> no if_done_o pulse, and a new fetch of 0x200 completes with the correct word.
